// File: rtl/rank_match_pkg.sv
// rank_match_pkg: shared FSM state type, width helpers and RAM latency for the rank matcher
package rank_match_pkg;
  typedef enum logic [2:0] {IDLE, CAPTURE, SCAN, DRAIN, ARGMIN, DONE} state_t;
  localparam int RD_LAT = 2;
  function automatic int score_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  function automatic int index_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/template_score_bank.sv
// template_score_bank: per-template XOR-mismatch accumulators with an indexed read port
// Ports: clk, rst_n (async active-low); clr zeroes all accumulators; en adds tmpl[t]^pix to
// accumulator t for every t; rd_idx/rd_score read one accumulator combinationally.
module template_score_bank #(
  parameter int N  = 13,
  parameter int SW = 11,
  parameter int IW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  input  logic [N-1:0]  tmpl,
  input  logic          pix,
  input  logic [IW-1:0] rd_idx,
  output logic [SW-1:0] rd_score
);
  logic [SW-1:0] acc [N];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '{default: '0};
    else if (clr) acc <= '{default: '0};
    else if (en) for (int i = 0; i < N; i++) acc[i] <= acc[i] + SW'(tmpl[i] ^ pix);
  end
  assign rd_score = acc[rd_idx];
endmodule

// File: rtl/rank_template_matcher.sv
// rank_template_matcher: captures a card's rank-corner window and reports the closest 1-bit template
// Ports: clk, rst_n (async active-low); hcount/vcount/mask pixel stream; left_edge/top_edge
// sampled on start; busy; result_valid/result_ready handshake carrying best_index/best_score.
// Build option MATCH_THRESHOLD_EN adds parameter MAX_SCORE and output no_match.
// ROM_IMAGE holds the template ROM: word a at [a*NUM_TEMPLATES +: NUM_TEMPLATES], bit t = template t.
module rank_template_matcher
  import rank_match_pkg::*;
#(
  parameter int NUM_TEMPLATES = 13,
  parameter int CORNER_WIDTH  = 28,
  parameter int RANK_HEIGHT   = 40,
  parameter int X_OFFSET      = 4,
  parameter logic [NUM_TEMPLATES*CORNER_WIDTH*RANK_HEIGHT-1:0] ROM_IMAGE = '0
`ifdef MATCH_THRESHOLD_EN
  , parameter int MAX_SCORE   = 300
`endif
) (
  input  logic                                              clk,
  input  logic                                              rst_n,
  input  logic [10:0]                                       hcount,
  input  logic [9:0]                                        vcount,
  input  logic                                              mask,
  input  logic [10:0]                                       left_edge,
  input  logic [9:0]                                        top_edge,
  input  logic                                              start,
  output logic                                              busy,
  output logic                                              result_valid,
  input  logic                                              result_ready,
  output logic [index_w(NUM_TEMPLATES)-1:0]                 best_index,
  output logic [score_w(CORNER_WIDTH*RANK_HEIGHT)-1:0]      best_score
`ifdef MATCH_THRESHOLD_EN
  , output logic                                            no_match
`endif
);
  localparam int DEPTH = CORNER_WIDTH * RANK_HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int SW    = score_w(DEPTH);
  localparam int IW    = index_w(NUM_TEMPLATES);
  state_t state, nxt;
  logic [10:0] le;
  logic [9:0] te;
  logic [AW-1:0] waddr, raddr;
  logic [RD_LAT-1:0] vld;
  logic [IW-1:0] aidx;
  logic cap_mem [DEPTH];
  logic [RD_LAT-1:0] cap_pipe;
  logic [NUM_TEMPLATES-1:0] rom_pipe [RD_LAT];
  logic [11:0] hx0, hx1;
  logic [10:0] vy1;
  logic in_win, wr, rd, clr, last_wr, last_t, upd;
  logic [SW-1:0] score, fin;
  // window bounds are widened so edges near the frame limit cannot wrap
  assign hx0     = {1'b0, le} + 12'(X_OFFSET);
  assign hx1     = hx0 + 12'(CORNER_WIDTH);
  assign vy1     = {1'b0, te} + 11'(RANK_HEIGHT);
  assign in_win  = ({1'b0, hcount} >= hx0) && ({1'b0, hcount} < hx1) && (vcount >= te) && ({1'b0, vcount} < vy1);
  assign last_wr = wr && (waddr == AW'(DEPTH - 1));
  assign last_t  = aidx == IW'(NUM_TEMPLATES - 1);
  // the first template always loads; later ones only replace on strictly lower score
  assign upd     = (aidx == '0) || (score < best_score);
  assign fin     = upd ? score : best_score;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? CAPTURE : IDLE;
      CAPTURE: nxt = last_wr ? SCAN : CAPTURE;
      SCAN:    nxt = (raddr == AW'(DEPTH - 1)) ? DRAIN : SCAN;
      DRAIN:   nxt = vld[0] ? DRAIN : ARGMIN;
      ARGMIN:  nxt = last_t ? DONE : ARGMIN;
      DONE:    nxt = result_ready ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    busy         = state != IDLE;
    result_valid = state == DONE;
    wr           = (state == CAPTURE) && in_win;
    rd           = state == SCAN;
    clr          = (state == IDLE) && start;
  end
  // capture RAM and template ROM, both with an RD_LAT-deep registered read path
  always_ff @(posedge clk) begin
    if (wr) cap_mem[waddr] <= mask;
    cap_pipe    <= {cap_pipe[RD_LAT-2:0], cap_mem[raddr]};
    rom_pipe[0] <= ROM_IMAGE[int'(raddr)*NUM_TEMPLATES +: NUM_TEMPLATES];
    for (int i = 1; i < RD_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      le         <= '0;
      te         <= '0;
      waddr      <= '0;
      raddr      <= '0;
      vld        <= '0;
      aidx       <= '0;
      best_index <= '0;
      best_score <= '0;
    end else begin
      if (clr) begin
        le    <= left_edge;
        te    <= top_edge;
        waddr <= '0;
        raddr <= '0;
        aidx  <= '0;
      end
      if (wr) waddr <= waddr + AW'(1);
      if (rd) raddr <= raddr + AW'(1);
      vld <= {vld[RD_LAT-2:0], rd};
      if (state == ARGMIN) begin
        aidx <= aidx + IW'(1);
        if (upd) begin
          best_index <= aidx;
          best_score <= score;
        end
      end
    end
  end
`ifdef MATCH_THRESHOLD_EN
  // evaluated on the final ARGMIN step so it is valid on the first DONE cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) no_match <= 1'b0;
    else if ((state == ARGMIN) && last_t) no_match <= int'(fin) > MAX_SCORE;
  end
`else
  logic unused_fin;
  assign unused_fin = ^fin;
`endif
  template_score_bank #(.N(NUM_TEMPLATES), .SW(SW), .IW(IW)) u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .en       (vld[RD_LAT-1]),
    .tmpl     (rom_pipe[RD_LAT-1]),
    .pix      (cap_pipe[RD_LAT-1]),
    .rd_idx   (aidx),
    .rd_score (score)
  );
endmodule

// File: tb/tb_rank_template_matcher.sv
// tb_rank_template_matcher: directed and randomized checks of rank_template_matcher against a reference model
module tb_rank_template_matcher;
  localparam int CW = 4, RH = 2, NT = 3, XO = 0, DEPTH = CW * RH;
  localparam int SW = 4, IW = 2;
  function automatic logic tbit(input int t, input int a);
    return (t == 0) ? 1'b0 : (t == 1) ? 1'b1 : (a % 2 == 0);
  endfunction
  function automatic logic [NT*DEPTH-1:0] rom_img();
    logic [NT*DEPTH-1:0] r;
    r = '0;
    for (int a = 0; a < DEPTH; a++)
      for (int t = 0; t < NT; t++) r[a*NT+t] = tbit(t, a);
    return r;
  endfunction
  localparam logic [NT*DEPTH-1:0] ROM = rom_img();
  logic clk, rst_n, mask, start, busy, result_valid, result_ready;
  logic [10:0] hcount, left_edge;
  logic [9:0] vcount, top_edge;
  logic [IW-1:0] best_index;
  logic [SW-1:0] best_score;
`ifdef MATCH_THRESHOLD_EN
  logic no_match;
`endif
  int cyc = 0, wcyc = 0, tests = 0, fails = 0;
  rank_template_matcher #(
    .NUM_TEMPLATES(NT), .CORNER_WIDTH(CW), .RANK_HEIGHT(RH), .X_OFFSET(XO), .ROM_IMAGE(ROM)
`ifdef MATCH_THRESHOLD_EN
    , .MAX_SCORE(3)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .mask(mask),
    .left_edge(left_edge), .top_edge(top_edge), .start(start), .busy(busy),
    .result_valid(result_valid), .result_ready(result_ready),
    .best_index(best_index), .best_score(best_score)
`ifdef MATCH_THRESHOLD_EN
    , .no_match(no_match)
`endif
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  // pattern bit 7 is pixel 0 (raster order inside the window)
  task automatic model(input logic [7:0] pat, output int bi, output int bs);
    int s;
    bi = 0;
    bs = DEPTH + 1;
    for (int t = 0; t < NT; t++) begin
      s = 0;
      for (int a = 0; a < DEPTH; a++) s += int'(pat[7-a] ^ tbit(t, a));
      if (s < bs) begin
        bs = s;
        bi = t;
      end
    end
  endtask
  // streams a border of outside pixels around the window, with random mask outside
  task automatic capture(input logic [7:0] pat, input logic [10:0] le, input logic [9:0] te);
    logic ins;
    int a;
    left_edge = le;
    top_edge  = te;
    start     = 1;
    @(negedge clk);
    start = 0;
    for (int v = int'(te) - 1; v <= int'(te) + RH; v++)
      for (int h = int'(le) + XO - 1; h <= int'(le) + XO + CW; h++) begin
        ins = (v >= int'(te)) && (v < int'(te) + RH) && (h >= int'(le) + XO) && (h < int'(le) + XO + CW);
        a = (v - int'(te)) * CW + (h - int'(le) - XO);
        hcount = 11'(h);
        vcount = 10'(v);
        mask = ins ? pat[7-a] : 1'($urandom);
        if (ins && a == DEPTH - 1) wcyc = cyc;
        @(negedge clk);
      end
    hcount = '0;
    vcount = '0;
    mask   = 0;
  endtask
  task automatic expect_result(input logic [7:0] pat, input string tag);
    int bi, bs, n;
    model(pat, bi, bs);
    n = 0;
    while (!result_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 32'(result_valid), 1);
    chk({tag, "_latency"}, cyc - wcyc, DEPTH + 2 + NT + 1);
    chk({tag, "_index"}, 32'(best_index), bi);
    chk({tag, "_score"}, 32'(best_score), bs);
    chk({tag, "_busy"}, 32'(busy), 1);
`ifdef MATCH_THRESHOLD_EN
    chk({tag, "_no_match"}, 32'(no_match), 32'(bs > 3));
`endif
  endtask
  task automatic consume(input string tag);
    result_ready = 1;
    @(negedge clk);
    result_ready = 0;
    chk({tag, "_valid_after"}, 32'(result_valid), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask
  initial begin
    logic [7:0] pat;
    int bi, bs;
    rst_n = 0; start = 0; result_ready = 0; mask = 0;
    hcount = '0; vcount = '0; left_edge = '0; top_edge = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_index", 32'(best_index), 0);
    chk("rst_score", 32'(best_score), 0);
`ifdef MATCH_THRESHOLD_EN
    chk("rst_no_match", 32'(no_match), 0);
`endif
    rst_n = 1;
    @(negedge clk);
    capture(8'b11111111, 11'd10, 10'd5);
    expect_result(8'b11111111, "ones");
    consume("ones");
    capture(8'b10101010, 11'd300, 10'd77);
    expect_result(8'b10101010, "alt");
    consume("alt");
    capture(8'b11110000, 11'd1500, 10'd900);
    expect_result(8'b11110000, "tie");
    model(8'b11110000, bi, bs);
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      left_edge = 11'($urandom);
      @(negedge clk);
      start = 0;
      chk("hold_valid", 32'(result_valid), 1);
      chk("hold_busy", 32'(busy), 1);
      chk("hold_index", 32'(best_index), bi);
      chk("hold_score", 32'(best_score), bs);
    end
    start = 1;
    result_ready = 1;
    @(negedge clk);
    start = 0;
    result_ready = 0;
    chk("hs_start_valid", 32'(result_valid), 0);
    chk("hs_start_busy", 32'(busy), 0);
    @(negedge clk);
    chk("hs_start_idle", 32'(busy), 0);
    result_ready = 1;
    chk("early_ready_valid", 32'(result_valid), 0);
    capture(8'b00000001, 11'd40, 10'd20);
    expect_result(8'b00000001, "early_ready");
    @(negedge clk);
    chk("early_ready_done", 32'(result_valid), 0);
    chk("early_ready_busy", 32'(busy), 0);
    result_ready = 0;
    capture(8'b11111111, 11'd600, 10'd300);
    chk("scan_busy", 32'(busy), 1);
    rst_n = 0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(result_valid), 0);
    @(negedge clk);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("abort_no_result", 32'(result_valid), 0);
    capture(8'b10101010, 11'd123, 10'd45);
    expect_result(8'b10101010, "post_abort");
    consume("post_abort");
    for (int k = 0; k < 8; k++) begin
      pat = 8'($urandom);
      capture(pat, 11'($urandom_range(1, 2000)), 10'($urandom_range(1, 1000)));
      expect_result(pat, "rand");
      repeat ($urandom_range(0, 4)) @(negedge clk);
      chk("rand_wait_valid", 32'(result_valid), 1);
      consume("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
